// File: rtl/lag_fifo_csr_pkg.sv
// rtl/lag_fifo_csr_pkg.sv - register map, bit positions and sizing helpers for lag_fifo_csr
// Contents:
//   addr_e           CPU register addresses
//   ST_* / CT_*      STATUS and CONTROL bit positions
//   bits_per_xcorr   bits needed for one signed lag in -max_lags..+max_lags
//   words_per_vec    32-bit CPU words needed to carry one lag vector
package lag_csr_pkg;

    typedef enum logic [2:0] {
        STATUS  = 3'd0,
        CONTROL = 3'd1,
        HEAD    = 3'd2,
        DROPS   = 3'd3,
        DEBUG   = 3'd4,
        THRESH  = 3'd5
    } addr_e;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_IRQ       = 3;
    localparam int ST_LEVEL_LSB = 8;
    localparam int ST_ENABLE    = 24;
    localparam int ST_SHOOT     = 25;

    localparam int CT_CAPTURE = 0;
    localparam int CT_IRQ_EN  = 1;
    localparam int CT_FLUSH   = 2;
    localparam int CT_OVF_CLR = 3;

    function automatic int bits_per_xcorr(input int max_lags);
        return $clog2(2 * max_lags + 1);
    endfunction

    function automatic int words_per_vec(input int lag_w);
        return (lag_w + 31) / 32;
    endfunction

endpackage

// File: rtl/lag_fifo_csr_if.sv
// rtl/lag_fifo_csr_if.sv - CPU register bus between the Nios master and lag_fifo_csr
// Signals:
//   address[2:0]    register select
//   read, write     access strobes
//   writedata[31:0] write data
//   readdata[31:0]  registered read data, one cycle after read
//   irq             level interrupt from the slave
interface lag_fifo_csr_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, read, write, writedata, input readdata, irq);
    modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/lag_sample_fifo.sv
// rtl/lag_sample_fifo.sv - synchronous lag-vector FIFO with flush and fill level
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   push, din   write request and data; accepted when not full or when popping in the same cycle
//   pop         read request; ignored when empty
//   flush       empties the FIFO, overriding push and pop
//   head        oldest entry (valid when !empty)
//   full, empty, level  occupancy status
module lag_sample_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still fits.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/lag_fifo_csr.sv
// rtl/lag_fifo_csr.sv - CPU-facing lag-vector FIFO with status/control/debug registers and fill interrupt
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   bus                          register bus slave (address/read/write/writedata/readdata/irq)
//   dataIn, dataInValid          packed lag vector (channel 0 in LSBs) and push qualifier
//   dataEnable, dataShoot        live status bits mirrored into STATUS
//   debugData, debugDataValid    debug word and its latch strobe
module lag_fifo_csr
    import lag_csr_pkg::*;
#(
    parameter int NUM_XCORRS = 6,
    parameter int MAX_LAGS   = 11,
    parameter int FIFO_DEPTH = 16,
    parameter int CPU_BITS   = 32
) (
    input  logic                                             clk,
    input  logic                                             reset,
    lag_fifo_csr_if.slave                                    bus,
    input  logic [NUM_XCORRS*bits_per_xcorr(MAX_LAGS)-1:0]   dataIn,
    input  logic                                             dataInValid,
    input  logic                                             dataEnable,
    input  logic                                             dataShoot,
    input  logic [31:0]                                      debugData,
    input  logic                                             debugDataValid
);
    localparam int BPX   = bits_per_xcorr(MAX_LAGS);
    localparam int LAG_W = NUM_XCORRS * BPX;
    localparam int WORDS = words_per_vec(LAG_W);
    localparam int WPW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    // Padded to every value wptr can encode so the word select never runs off the end.
    localparam int PADW  = (1 << WPW) * 32;
    localparam int LW    = $clog2(FIFO_DEPTH + 1);

    logic [LAG_W-1:0]    head;
    logic                full, empty;
    logic [LW-1:0]       level;
    logic                capture_en, irq_en, ovf, irq_q;
    logic [15:0]         drops;
    logic [31:0]         debug_q;
    logic [8:0]          thresh, thresh_clamped;
    logic [WPW-1:0]      wptr;
    logic [PADW-1:0]     padded;
    logic [31:0]         head_word, readdata_q;
    logic [CPU_BITS-1:0] rd_mux;
    logic                ctrl_wr, thresh_wr, flush, ovf_clr, head_rd, pop, push, drop;
    logic                unused_wd;

    assign ctrl_wr   = bus.write && (bus.address == CONTROL);
    assign thresh_wr = bus.write && (bus.address == THRESH);
    assign flush     = ctrl_wr && bus.writedata[CT_FLUSH];
    assign ovf_clr   = ctrl_wr && bus.writedata[CT_OVF_CLR];
    assign head_rd   = bus.read && (bus.address == HEAD) && !empty;
    assign pop       = head_rd && (wptr == WPW'(WORDS - 1));
    assign push      = capture_en && dataInValid && !flush;
    assign drop      = push && full && !pop;
    assign unused_wd = ^bus.writedata[31:9];

    lag_sample_fifo #(.WIDTH(LAG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (dataIn),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign padded    = PADW'(head);
    assign head_word = padded[{wptr, 5'd0} +: 32];

    always_comb begin
        thresh_clamped = bus.writedata[8:0];
        if (bus.writedata[8:0] == 9'd0)
            thresh_clamped = 9'd1;
        else if (bus.writedata[8:0] > 9'(FIFO_DEPTH))
            thresh_clamped = 9'(FIFO_DEPTH);
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            STATUS: begin
                rd_mux[ST_EMPTY]              = empty;
                rd_mux[ST_FULL]               = full;
                rd_mux[ST_OVF]                = ovf;
                rd_mux[ST_IRQ]                = irq_q;
                rd_mux[ST_LEVEL_LSB +: 9]     = 9'(level);
                rd_mux[ST_ENABLE]             = dataEnable;
                rd_mux[ST_SHOOT]              = dataShoot;
            end
            CONTROL: begin
                rd_mux[CT_CAPTURE] = capture_en;
                rd_mux[CT_IRQ_EN]  = irq_en;
            end
            HEAD:    rd_mux[31:0]  = empty ? 32'd0 : head_word;
            DROPS:   rd_mux[15:0]  = drops;
            DEBUG:   rd_mux[31:0]  = debug_q;
            THRESH:  rd_mux[8:0]   = thresh;
            default: rd_mux        = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            capture_en <= 1'b0;
            irq_en     <= 1'b0;
            thresh     <= 9'(FIFO_DEPTH);
            ovf        <= 1'b0;
            drops      <= '0;
            debug_q    <= '0;
            wptr       <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            if (ctrl_wr) begin
                capture_en <= bus.writedata[CT_CAPTURE];
                irq_en     <= bus.writedata[CT_IRQ_EN];
            end
            if (thresh_wr) thresh <= thresh_clamped;
            if (debugDataValid) debug_q <= debugData;
            // A drop in the same cycle as ovf_clr survives the clear.
            if (drop) begin
                ovf   <= 1'b1;
                drops <= ovf_clr ? 16'd1 : ((drops == 16'hFFFF) ? drops : drops + 16'd1);
            end else if (ovf_clr) begin
                ovf   <= 1'b0;
                drops <= '0;
            end
            if (flush)
                wptr <= '0;
            else if (head_rd)
                wptr <= pop ? '0 : wptr + WPW'(1);
            irq_q <= irq_en && (9'(level) >= thresh);
            if (bus.read) readdata_q <= rd_mux[31:0];
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_lag_fifo_csr.sv
// tb/tb_lag_fifo_csr.sv - self-checking bench for lag_fifo_csr
module tb_lag_fifo_csr;
    localparam int DEPTH = 16;
    localparam int WORDS0 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [29:0] din0;
    logic        v0, en0, sh0, dv0;
    logic [31:0] dbg0;
    logic [47:0] din1;
    logic        v1;

    lag_fifo_csr_if b0();
    lag_fifo_csr_if b1();

    lag_fifo_csr dut0 (
        .clk(clk), .reset(rst0), .bus(b0),
        .dataIn(din0), .dataInValid(v0), .dataEnable(en0), .dataShoot(sh0),
        .debugData(dbg0), .debugDataValid(dv0)
    );

    lag_fifo_csr #(.NUM_XCORRS(8), .MAX_LAGS(31), .FIFO_DEPTH(16), .CPU_BITS(32)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1),
        .dataIn(din1), .dataInValid(v1), .dataEnable(1'b0), .dataShoot(1'b0),
        .debugData(32'd0), .debugDataValid(1'b0)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for dut0: FIFO as a queue of whole vectors.
    logic [63:0] mq[$];
    int          m_wp, m_drops, m_thr, m_sz;
    bit          m_ovf, m_cap, m_ien, model_on;
    logic [31:0] m_dbg, exp_rd, m_rd, m_wd;
    bit          exp_irq, m_hr, m_pp, m_fl, m_oc, m_ps, m_dr;

    always @(posedge clk) begin
        if (rst0) begin
            mq.delete();
            m_wp = 0; m_drops = 0; m_thr = DEPTH; m_ovf = 0; m_cap = 0; m_ien = 0;
            m_dbg = 0; exp_rd = 0; exp_irq = 0;
        end else begin
            m_sz = mq.size();
            m_wd = b0.writedata;
            m_rd = 32'd0;
            case (b0.address)
                3'd0: m_rd = {6'd0, sh0, en0, 7'd0, 9'(m_sz), 4'd0, exp_irq, m_ovf,
                              (m_sz == DEPTH), (m_sz == 0)};
                3'd1: m_rd = {30'd0, m_ien, m_cap};
                3'd2: m_rd = (m_sz == 0) ? 32'd0 : 32'(mq[0] >> (32 * m_wp));
                3'd3: m_rd = 32'(m_drops);
                3'd4: m_rd = m_dbg;
                3'd5: m_rd = 32'(m_thr);
                default: m_rd = 32'd0;
            endcase
            if (b0.read) exp_rd = m_rd;
            exp_irq = m_ien && (m_sz >= m_thr);

            m_fl = b0.write && (b0.address == 3'd1) && m_wd[2];
            m_oc = b0.write && (b0.address == 3'd1) && m_wd[3];
            m_hr = b0.read && (b0.address == 3'd2) && (m_sz > 0);
            m_pp = m_hr && (m_wp == WORDS0 - 1);
            m_ps = m_cap && v0 && !m_fl;
            m_dr = m_ps && (m_sz == DEPTH) && !m_pp;
            if (m_fl) begin
                mq.delete();
                m_wp = 0;
            end else begin
                if (m_hr) m_wp = m_pp ? 0 : m_wp + 1;
                if (m_pp) void'(mq.pop_front());
                if (m_ps && !m_dr) mq.push_back(64'(din0));
            end
            if (m_dr) begin
                m_ovf = 1;
                m_drops = m_oc ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
            end else if (m_oc) begin
                m_ovf = 0;
                m_drops = 0;
            end
            if (b0.write && b0.address == 3'd1) begin
                m_cap = m_wd[0];
                m_ien = m_wd[1];
            end
            if (b0.write && b0.address == 3'd5)
                m_thr = (m_wd[8:0] == 0) ? 1 : ((int'(m_wd[8:0]) > DEPTH) ? DEPTH : int'(m_wd[8:0]));
            if (dv0) m_dbg = dbg0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_readdata", b0.readdata, exp_rd);
            chk("model_irq", {31'd0, b0.irq}, {31'd0, exp_irq});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd0(input logic [2:0] a, output logic [31:0] d);
        b0.address = a; b0.read = 1'b1;
        tick();
        d = b0.readdata;
        b0.read = 1'b0;
    endtask

    task automatic wr0(input logic [2:0] a, input logic [31:0] d);
        b0.address = a; b0.writedata = d; b0.write = 1'b1;
        tick();
        b0.write = 1'b0;
    endtask

    task automatic push0(input logic [29:0] d);
        din0 = d; v0 = 1'b1;
        tick();
        v0 = 1'b0;
    endtask

    task automatic rd1(input logic [2:0] a, output logic [31:0] d);
        b1.address = a; b1.read = 1'b1;
        tick();
        d = b1.readdata;
        b1.read = 1'b0;
    endtask

    task automatic wr1(input logic [2:0] a, input logic [31:0] d);
        b1.address = a; b1.writedata = d; b1.write = 1'b1;
        tick();
        b1.write = 1'b0;
    endtask

    task automatic push1(input logic [47:0] d);
        din1 = d; v1 = 1'b1;
        tick();
        v1 = 1'b0;
    endtask

    logic [31:0] d;
    int          ph;

    initial begin
        model_on = 0;
        b0.address = 0; b0.read = 0; b0.write = 0; b0.writedata = 0;
        b1.address = 0; b1.read = 0; b1.write = 0; b1.writedata = 0;
        din0 = 0; v0 = 0; en0 = 0; sh0 = 0; dv0 = 0; dbg0 = 0;
        din1 = 0; v1 = 0;
        rst0 = 1; rst1 = 1;
        @(negedge clk);
        model_on = 1;
        tick(); tick();
        rst0 = 0; rst1 = 0;
        tick();

        // Reset state
        rd0(3'd0, d); chk("t1_status", d, 32'h0000_0001);
        rd0(3'd5, d); chk("t1_thresh", d, 32'd16);

        // Basic push then read back
        wr0(3'd1, 32'h1);
        push0(30'h2AAAAAAA);
        push0(30'h15555555);
        rd0(3'd2, d); chk("t2_head0", d, 32'h2AAAAAAA);
        rd0(3'd2, d); chk("t2_head1", d, 32'h15555555);
        rd0(3'd0, d); chk("t2_status_empty", d, 32'h0000_0001);

        // Overflow: 17 pushes into a 16-deep FIFO
        for (int i = 1; i <= 17; i++) push0(30'(i));
        rd0(3'd0, d); chk("t3_status_full_ovf", d, 32'h0000_1006);
        rd0(3'd3, d); chk("t3_drops", d, 32'd1);
        wr0(3'd1, 32'h9);
        rd0(3'd0, d); chk("t3_status_ovf_clr", d, 32'h0000_1002);
        rd0(3'd3, d); chk("t3_drops_clr", d, 32'd0);

        // Full FIFO, push and pop in the same cycle
        din0 = 30'd100; v0 = 1'b1;
        rd0(3'd2, d);
        v0 = 1'b0;
        chk("t4_head_first", d, 32'd1);
        rd0(3'd0, d); chk("t4_level_16", d, 32'h0000_1002);
        rd0(3'd3, d); chk("t4_drops_same", d, 32'd0);
        rd0(3'd2, d); chk("t4_head_second", d, 32'd2);
        wr0(3'd1, 32'h5);
        rd0(3'd0, d); chk("t4_flush_empty", d, 32'h0000_0001);

        // Fill-threshold interrupt
        wr0(3'd1, 32'h3);
        wr0(3'd5, 32'd4);
        for (int i = 0; i < 4; i++) push0(30'(32'h100 + i));
        chk("t5_irq_not_yet", {31'd0, b0.irq}, 32'd0);
        tick();
        chk("t5_irq_rise", {31'd0, b0.irq}, 32'd1);
        rd0(3'd2, d); chk("t5_head", d, 32'h100);
        chk("t5_irq_hold", {31'd0, b0.irq}, 32'd1);
        tick();
        chk("t5_irq_fall", {31'd0, b0.irq}, 32'd0);
        wr0(3'd5, 32'd0);
        rd0(3'd5, d); chk("t5_thresh_clamp_lo", d, 32'd1);
        wr0(3'd5, 32'd200);
        rd0(3'd5, d); chk("t5_thresh_clamp_hi", d, 32'd16);
        wr0(3'd2, 32'hFFFF_FFFF);
        rd0(3'd2, d); chk("t5_ro_write_ignored", d, 32'h101);

        // Two-word vectors on the wide instance
        wr1(3'd1, 32'h1);
        push1(48'hABCD_12345678);
        rd1(3'd2, d); chk("t6_word0", d, 32'h12345678);
        rd1(3'd2, d); chk("t6_word1", d, 32'h0000ABCD);
        rd1(3'd0, d); chk("t6_popped", d, 32'h0000_0001);
        push1(48'h1111_22223333);
        rd1(3'd2, d); chk("t6_partial", d, 32'h22223333);
        b1.address = 3'd1; b1.writedata = 32'h5; b1.write = 1'b1;
        din1 = 48'h9999_88887777; v1 = 1'b1;
        tick();
        b1.write = 1'b0; v1 = 1'b0;
        rd1(3'd0, d); chk("t6_flush_beats_push", d, 32'h0000_0001);
        push1(48'h4444_55556666);
        rd1(3'd2, d); chk("t6_wptr_reset", d, 32'h55556666);
        rd1(3'd2, d); chk("t6_wptr_word1", d, 32'h00004444);
        rd1(3'd0, d); chk("t6_empty_end", d, 32'h0000_0001);

        // Randomized traffic on dut0, alternating fill-heavy and drain-heavy phases
        wr0(3'd1, 32'h1);
        for (int n = 0; n < 4000; n++) begin
            ph = (n / 400) % 2;
            din0 = 30'($urandom);
            v0   = ($urandom_range(0, 9) < ((ph == 1) ? 3 : 8));
            en0  = 1'($urandom);
            sh0  = 1'($urandom);
            dbg0 = $urandom;
            dv0  = ($urandom_range(0, 7) == 0);
            b0.address = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) b0.address = 3'd2;
            b0.read  = ($urandom_range(0, 9) < ((ph == 1) ? 8 : 2));
            b0.write = ($urandom_range(0, 11) == 0);
            m_wd = $urandom;
            if (b0.address == 3'd1) begin
                m_wd[0] = ($urandom_range(0, 7) != 0);
                m_wd[2] = ($urandom_range(0, 15) == 0);
                m_wd[3] = ($urandom_range(0, 5) == 0);
            end
            if (b0.address == 3'd5) m_wd[8:0] = 9'($urandom_range(0, 20));
            b0.writedata = m_wd;
            tick();
        end
        b0.read = 0; b0.write = 0; v0 = 0; dv0 = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
